// File: rtl/hub75_bcm_driver_if.sv
// Frame-buffer read port: the driver issues address + strobe, RAM returns data one cycle later.
interface hub75_bcm_driver_if #(
  parameter int AW = 3,
  parameter int DW = 12
);
  logic [AW-1:0] ram_addr;
  logic          ram_rd;
  logic [DW-1:0] ram_data;

  modport master (output ram_addr, output ram_rd, input ram_data);
  modport slave  (input ram_addr, input ram_rd, output ram_data);
endinterface

// File: rtl/hub75_bcm_driver.sv
// HUB75 driver with BCM planes, chained panels and clock-enabled shift clock.
// Panel pins trail the FSM by one register so shifted data settles CLK_DIV cycles before sclk rises.
module hub75_bcm_driver #(
  parameter int WIDTH   = 96,
  parameter int HEIGHT  = 48,
  parameter int CHAINED = 1,
  parameter int BPC     = 4,
  parameter int CLK_DIV = 2,
  parameter int BASE_ON = 4,
  parameter int AW      = $clog2((HEIGHT / 2) * WIDTH * CHAINED),
  parameter int RW      = $clog2(HEIGHT / 2)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  hub75_bcm_driver_if.master ram,
  output logic              sclk,
  output logic              lat,
  output logic              oe,
  output logic              r0,
  output logic              g0,
  output logic              b0,
  output logic              r1,
  output logic              g1,
  output logic              b1,
  output logic [RW-1:0]     o_row_select,
  output logic              o_frame_done
);
  localparam int R  = HEIGHT / 2;
  localparam int C  = WIDTH * CHAINED;
  localparam int CW = (C > 1) ? $clog2(C) : 1;
  localparam int PW = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int OW = $clog2((BASE_ON << (BPC - 1)) + 1);

  typedef enum logic [2:0] {IDLE, SHIFT_RD, SHIFT_LO, SHIFT_HI, LATCH, DISPLAY} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] col, col_nxt;
  logic [PW-1:0] plane, plane_nxt;
  logic [RW-1:0] row, row_nxt;
  logic [DW-1:0] div, div_nxt;
  logic [OW-1:0] on, on_nxt;
  logic [OW-1:0] on_len;
  logic          frame_end;

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    plane_nxt = plane;
    row_nxt   = row;
    div_nxt   = div;
    on_nxt    = on;
    frame_end = 1'b0;
    on_len    = OW'(BASE_ON) << plane;
    case (state)
      IDLE: begin
        if (i_enable) begin
          state_nxt = SHIFT_RD;
          col_nxt   = '0;
          plane_nxt = '0;
          row_nxt   = '0;
        end
      end
      SHIFT_RD: begin
        state_nxt = SHIFT_LO;
        div_nxt   = '0;
      end
      SHIFT_LO: begin
        if (div == DW'(CLK_DIV - 1)) begin
          div_nxt   = '0;
          state_nxt = SHIFT_HI;
        end else begin
          div_nxt = div + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (div == DW'(CLK_DIV - 1)) begin
          div_nxt = '0;
          if (col == CW'(C - 1)) begin
            col_nxt   = '0;
            state_nxt = LATCH;
          end else begin
            col_nxt   = col + 1'b1;
            state_nxt = SHIFT_RD;
          end
        end else begin
          div_nxt = div + 1'b1;
        end
      end
      LATCH: begin
        state_nxt = DISPLAY;
        on_nxt    = '0;
      end
      DISPLAY: begin
        if (on == on_len - 1'b1) begin
          state_nxt = SHIFT_RD;
          if (plane != PW'(BPC - 1)) begin
            plane_nxt = plane + 1'b1;
          end else begin
            plane_nxt = '0;
            if (row != RW'(R - 1)) begin
              row_nxt = row + 1'b1;
            end else begin
              // enable is only looked at here, so a mid-frame drop finishes the frame
              row_nxt   = '0;
              frame_end = 1'b1;
              if (!i_enable) state_nxt = IDLE;
            end
          end
        end else begin
          on_nxt = on + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      col          <= '0;
      plane        <= '0;
      row          <= '0;
      div          <= '0;
      on           <= '0;
      ram.ram_addr <= '0;
      ram.ram_rd   <= 1'b0;
      sclk         <= 1'b0;
      lat          <= 1'b0;
      oe           <= 1'b1;
      {r0, g0, b0, r1, g1, b1} <= '0;
      o_row_select <= '0;
      o_frame_done <= 1'b0;
    end else begin
      state        <= state_nxt;
      col          <= col_nxt;
      plane        <= plane_nxt;
      row          <= row_nxt;
      div          <= div_nxt;
      on           <= on_nxt;
      ram.ram_rd   <= (state_nxt == SHIFT_RD);
      if (state_nxt == SHIFT_RD)
        ram.ram_addr <= AW'(int'(row_nxt) * C + int'(col_nxt));
      sclk         <= (state == SHIFT_HI);
      lat          <= (state == LATCH);
      oe           <= (state != DISPLAY);
      o_frame_done <= frame_end;
      if (state == LATCH && plane == '0)
        o_row_select <= row;
      // read data arrives during the first SHIFT_LO cycle
      if (state == SHIFT_LO && div == '0) begin
        r0 <= ram.ram_data[5 * BPC + int'(plane)];
        g0 <= ram.ram_data[4 * BPC + int'(plane)];
        b0 <= ram.ram_data[3 * BPC + int'(plane)];
        r1 <= ram.ram_data[2 * BPC + int'(plane)];
        g1 <= ram.ram_data[1 * BPC + int'(plane)];
        b1 <= ram.ram_data[int'(plane)];
      end
    end
  end
endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Scoreboard bench: stimulus pushes expected reads, shifted pixels, latches and frame ends; a monitor pops and compares.
module tb_hub75_bcm_driver;
  localparam int W = 4, H = 4, CH = 1, BPC = 2, CD = 1, BO = 2;
  localparam int R = H / 2, C = W * CH, AW = 3, DW = 6 * BPC;
  localparam int C2 = 8, CD2 = 2, AW2 = 4;

  typedef struct {int row; int on_len; int gap;} lat_item_t;

  logic clk = 1'b0;
  logic rst, en, rst2, en2;
  logic sclk, lat, oe, r0, g0, b0, r1, g1, b1, frame_done;
  logic [0:0] row_sel;
  logic s_sclk, s_lat, s_oe, s_r0, s_g0, s_b0, s_r1, s_g1, s_b1, s_fd;
  logic [0:0] s_row_sel;

  hub75_bcm_driver_if #(.AW(AW), .DW(DW)) ram_if ();
  hub75_bcm_driver_if #(.AW(AW2), .DW(DW)) ram2_if ();

  hub75_bcm_driver #(.WIDTH(W), .HEIGHT(H), .CHAINED(CH), .BPC(BPC), .CLK_DIV(CD), .BASE_ON(BO)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .ram(ram_if),
    .sclk(sclk), .lat(lat), .oe(oe), .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .o_row_select(row_sel), .o_frame_done(frame_done));

  hub75_bcm_driver #(.WIDTH(W), .HEIGHT(H), .CHAINED(2), .BPC(BPC), .CLK_DIV(CD2), .BASE_ON(BO)) dut_scale (
    .i_clk(clk), .i_rst(rst2), .i_enable(en2), .ram(ram2_if),
    .sclk(s_sclk), .lat(s_lat), .oe(s_oe), .r0(s_r0), .g0(s_g0), .b0(s_b0), .r1(s_r1), .g1(s_g1), .b1(s_b1),
    .o_row_select(s_row_sel), .o_frame_done(s_fd));

  always #5 clk = ~clk;

  logic [DW-1:0] mem [R*C];
  always @(posedge clk) if (ram_if.ram_rd) ram_if.ram_data <= mem[ram_if.ram_addr];
  assign ram2_if.ram_data = '0;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- reference model ----------------
  int        addr_q[$];
  logic [5:0] shift_q[$];
  lat_item_t lat_q[$];
  int        fd_q[$];
  int        last_on;

  function automatic logic [5:0] pix_bits(input logic [DW-1:0] w, input int p);
    logic [5:0] res;
    logic [BPC-1:0] field;
    res = '0;
    for (int k = 0; k < 6; k++) begin
      field = w[(5 - k) * BPC +: BPC];  // k=0 r_top ... k=5 b_bot
      res[5 - k] = field[p];
    end
    return res;
  endfunction

  function automatic int frame_len();
    int s;
    s = 0;
    for (int p = 0; p < BPC; p++) s += C * (2 * CD + 1) + 1 + (BO << p);
    return R * s;
  endfunction

  function automatic void push_frame(input bit first);
    lat_item_t it;
    for (int row = 0; row < R; row++)
      for (int p = 0; p < BPC; p++) begin
        for (int c = 0; c < C; c++) begin
          addr_q.push_back(row * C + c);
          shift_q.push_back(pix_bits(mem[row * C + c], p));
        end
        it.row = row;
        it.on_len = BO << p;
        it.gap = (first && row == 0 && p == 0) ? 0 : last_on + C * (2 * CD + 1) + 1;
        last_on = BO << p;
        lat_q.push_back(it);
      end
    fd_q.push_back(first ? 0 : frame_len());
  endfunction

  function automatic void fill_mem();
    for (int i = 0; i < R * C; i++) mem[i] = DW'($urandom);
    mem[5] = {2'b10, 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 2'b01};
  endfunction

  // ---------------- monitor ----------------
  logic sclk_prev, oe_prev;
  logic [0:0] rs_prev;
  int oe_run, rises, cur_on, last_lat, last_fd, fd_count = 0;
  lat_item_t mit;
  int fgap;
  int s_row, s_plane, s_col, s_last, s_max, s_prev, s_wraps;

  always @(negedge clk) begin
    if (rst) begin
      sclk_prev = 1'b0; oe_prev = 1'b1; rs_prev = '0;
      oe_run = 0; rises = 0; cur_on = 0;
    end else begin
      if (ram_if.ram_rd) begin
        if (addr_q.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("ram_addr", ram_if.ram_addr, addr_q.pop_front());
      end
      if (sclk && !sclk_prev) begin
        rises++;
        if (shift_q.size() == 0) chk("sclk_unexpected", 1, 0);
        else chk("shift_data", {r0, g0, b0, r1, g1, b1}, shift_q.pop_front());
      end
      if (lat) begin
        if (lat_q.size() == 0) chk("lat_unexpected", 1, 0);
        else begin
          mit = lat_q.pop_front();
          chk("row_select", row_sel, mit.row);
          chk("sclk_rises_per_plane", rises, C);
          chk("lat_after_sclk_fall", sclk, 0);
          if (mit.gap != 0) chk("plane_period", cyc - last_lat, mit.gap);
          last_lat = cyc;
          cur_on = mit.on_len;
        end
        rises = 0;
      end
      if (!oe) begin
        oe_run++;
        chk("no_shift_while_lit", {sclk, lat}, 0);
      end else if (!oe_prev) begin
        chk("oe_low_cycles", oe_run, cur_on);
        oe_run = 0;
      end
      if (row_sel != rs_prev) chk("row_sel_only_in_latch", lat & oe, 1);
      if (frame_done) begin
        fd_count++;
        chk("frame_done_while_lit", oe, 0);
        if (fd_q.size() == 0) chk("frame_done_unexpected", 1, 0);
        else begin
          fgap = fd_q.pop_front();
          if (fgap != 0) chk("frame_period", cyc - last_fd, fgap);
        end
        last_fd = cyc;
      end
      sclk_prev = sclk; oe_prev = oe; rs_prev = row_sel;
    end
    // chained, slower-shift instance: address walk and column period
    if (rst2) begin
      s_row = 0; s_plane = 0; s_col = 0; s_max = 0; s_prev = -1; s_wraps = 0;
    end else if (ram2_if.ram_rd) begin
      chk("scale_addr", ram2_if.ram_addr, s_row * C2 + s_col);
      if (s_col > 0) chk("scale_col_period", cyc - s_last, 2 * CD2 + 1);
      if (s_prev == R * C2 - 1 && ram2_if.ram_addr == 0) s_wraps++;
      if (int'(ram2_if.ram_addr) > s_max) s_max = int'(ram2_if.ram_addr);
      s_prev = int'(ram2_if.ram_addr);
      s_last = cyc;
      s_col++;
      if (s_col == C2) begin
        s_col = 0; s_plane++;
        if (s_plane == BPC) begin s_plane = 0; s_row = (s_row + 1) % R; end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic void chk_reset(input string tag);
    chk({tag, "_oe"}, oe, 1);
    chk({tag, "_sclk"}, sclk, 0);
    chk({tag, "_lat"}, lat, 0);
    chk({tag, "_ram_rd"}, ram_if.ram_rd, 0);
    chk({tag, "_ram_addr"}, ram_if.ram_addr, 0);
    chk({tag, "_row_select"}, row_sel, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_data"}, {r0, g0, b0, r1, g1, b1}, 0);
  endfunction

  function automatic void chk_idle(input string tag);
    chk({tag, "_oe"}, oe, 1);
    chk({tag, "_reads_left"}, addr_q.size(), 0);
    chk({tag, "_shifts_left"}, shift_q.size(), 0);
    chk({tag, "_latches_left"}, lat_q.size(), 0);
    chk({tag, "_frames_left"}, fd_q.size(), 0);
  endfunction

  task automatic wait_fd(input int n);
    int target, k;
    target = fd_count + n;
    k = 0;
    while (fd_count < target && k < 3000) begin
      @(negedge clk); #1; k++;
    end
    if (fd_count < target) chk("frame_done_timeout", fd_count, target);
  endtask

  initial begin
    int k;
    rst = 1'b1; en = 1'b0; rst2 = 1'b1; en2 = 1'b0;
    fill_mem();
    repeat (3) @(posedge clk);
    #1 chk_reset("reset");

    // continuous frames, then enable dropped mid-frame
    @(negedge clk);
    push_frame(1); push_frame(0); push_frame(0);
    rst = 1'b0; rst2 = 1'b0; en = 1'b1; en2 = 1'b1;
    wait_fd(2);
    en = 1'b0;
    wait_fd(1);
    repeat (60) @(negedge clk);
    #1 chk_idle("enable_drop");

    // asynchronous reset while LEDs are lit
    fill_mem();
    push_frame(1);
    en = 1'b1;
    k = 0;
    while (oe !== 1'b0 && k < 500) begin @(negedge clk); k++; end
    chk("reached_display", oe, 0);
    #2 rst = 1'b1;
    #1 chk_reset("reset_mid");
    addr_q.delete(); shift_q.delete(); lat_q.delete(); fd_q.delete();
    push_frame(1); push_frame(0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    wait_fd(1);
    en = 1'b0;
    wait_fd(1);
    repeat (60) @(negedge clk);
    #1 chk_idle("after_reset");

    chk("scale_max_addr", s_max, R * C2 - 1);
    chk("scale_addr_wrapped", s_wraps > 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
